// File: rtl/post_tile_collector.sv
// Reassembles the POX-wide post-processing beat stream into full output tiles.
// Two tile buffers alternate, so input beats keep arriving while the downstream drains a tile.
module post_tile_collector #(
  parameter int POX        = 3,
  parameter int POY        = 3,
  parameter int CHANNEL_N  = 2,
  localparam int TILE_BEATS = CHANNEL_N * POY,
  localparam int BEAT_W     = POX * 16,
  localparam int TILE_W     = TILE_BEATS * BEAT_W,
  localparam int IDX_W      = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] post_out,
  input  logic              post_out_valid,
  output logic [TILE_W-1:0] tile_out,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic              overflow,
  output logic [15:0]       tile_count,
  output logic [IDX_W-1:0]  beat_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_BEATS - 1);

  logic [TILE_W-1:0] tile_buf [2];
  logic [1:0]        full;
  logic              wsel;
  logic              rsel;

  logic handshake;
  logic wfree;
  logic accept;
  logic last_beat;

  assign handshake = full[rsel] & tile_ready;
  // A full write slot is usable when it is the one being handed off this very cycle.
  assign wfree     = !full[wsel] || (handshake && (rsel == wsel));
  assign accept    = post_out_valid & wfree;
  assign last_beat = (beat_idx == LAST_IDX);

  assign tile_valid = full[rsel];
  assign tile_out   = tile_buf[rsel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_buf[0] <= '0;
      tile_buf[1] <= '0;
      full        <= '0;
      wsel        <= 1'b0;
      rsel        <= 1'b0;
      beat_idx    <= '0;
      overflow    <= 1'b0;
      tile_count  <= '0;
    end else begin
      if (handshake) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
        tile_count <= tile_count + 16'd1;
      end
      // The set below never targets the bit cleared above: a reused slot restarts at beat 0.
      if (accept) begin
        tile_buf[wsel][beat_idx*BEAT_W +: BEAT_W] <= post_out;
        if (last_beat) begin
          beat_idx   <= '0;
          full[wsel] <= 1'b1;
          wsel       <= ~wsel;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end else if (post_out_valid) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_post_tile_collector.sv
// Directed bench for post_tile_collector: ordering, stall, overflow, simultaneous free/write,
// asynchronous mid-tile reset and back-to-back streaming.
module tb_post_tile_collector;

  localparam int POX        = 3;
  localparam int POY        = 3;
  localparam int CHANNEL_N  = 2;
  localparam int TILE_BEATS = CHANNEL_N * POY;
  localparam int BEAT_W     = POX * 16;
  localparam int TILE_W     = TILE_BEATS * BEAT_W;
  localparam int IDX_W      = $clog2(TILE_BEATS);

  logic              clk = 1'b0;
  logic              rst;
  logic [BEAT_W-1:0] post_out;
  logic              post_out_valid;
  logic [TILE_W-1:0] tile_out;
  logic              tile_valid;
  logic              tile_ready;
  logic              overflow;
  logic [15:0]       tile_count;
  logic [IDX_W-1:0]  beat_idx;

  int pass_cnt = 0;
  int total_cnt = 0;

  post_tile_collector #(.POX(POX), .POY(POY), .CHANNEL_N(CHANNEL_N)) dut (
    .clk           (clk),
    .rst           (rst),
    .post_out      (post_out),
    .post_out_valid(post_out_valid),
    .tile_out      (tile_out),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .overflow      (overflow),
    .tile_count    (tile_count),
    .beat_idx      (beat_idx)
  );

  always #5 clk = ~clk;

  // Pixel p of a beat carries base+p.
  function automatic logic [BEAT_W-1:0] beat_val(input int base);
    logic [BEAT_W-1:0] v;
    for (int p = 0; p < POX; p++) v[p*16 +: 16] = 16'(base + p);
    return v;
  endfunction

  function automatic logic [TILE_W-1:0] tile_val(input int base);
    logic [TILE_W-1:0] t;
    for (int k = 0; k < TILE_BEATS; k++) t[k*BEAT_W +: BEAT_W] = beat_val(base + POX*k);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base);
    post_out       = beat_val(base);
    post_out_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    post_out_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    post_out       = '0;
    post_out_valid = 1'b0;
    tile_ready     = 1'b0;
    tick();
    tick();
    chk("reset_valid", TILE_W'(tile_valid), '0);
    chk("reset_out", tile_out, '0);
    chk("reset_ovf", TILE_W'(overflow), '0);
    chk("reset_count", TILE_W'(tile_count), '0);
    chk("reset_idx", TILE_W'(beat_idx), '0);
    rst = 1'b0;
    tick();

    // Ordering: values 0..17 in ascending slice order
    tile_ready = 1'b1;
    for (int k = 0; k < TILE_BEATS; k++) begin
      send(3*k);
      if (k == 2) chk("ord_idx3", TILE_W'(beat_idx), TILE_W'(3));
      if (k < TILE_BEATS-1) chk("ord_not_valid", TILE_W'(tile_valid), '0);
    end
    chk("ord_valid", TILE_W'(tile_valid), TILE_W'(1));
    chk("ord_tile", tile_out, tile_val(0));
    chk("ord_idx0", TILE_W'(beat_idx), '0);
    idle();
    chk("ord_pulse_end", TILE_W'(tile_valid), '0);
    chk("ord_count", TILE_W'(tile_count), TILE_W'(1));

    // Stall ping-pong
    tile_ready = 1'b0;
    for (int k = 0; k < TILE_BEATS; k++) send(100 + 3*k);
    chk("stall_valid_a", TILE_W'(tile_valid), TILE_W'(1));
    chk("stall_tile_a", tile_out, tile_val(100));
    for (int k = 0; k < TILE_BEATS; k++) send(200 + 3*k);
    chk("stall_hold_valid", TILE_W'(tile_valid), TILE_W'(1));
    chk("stall_hold_tile", tile_out, tile_val(100));
    chk("stall_ovf", TILE_W'(overflow), '0);
    post_out_valid = 1'b0;
    tile_ready     = 1'b1;
    tick();
    chk("stall_tile_b", tile_out, tile_val(200));
    chk("stall_valid_b", TILE_W'(tile_valid), TILE_W'(1));
    chk("stall_count_a", TILE_W'(tile_count), TILE_W'(2));
    tick();
    chk("stall_drained", TILE_W'(tile_valid), '0);
    chk("stall_count_b", TILE_W'(tile_count), TILE_W'(3));
    chk("stall_ovf2", TILE_W'(overflow), '0);

    // Simultaneous free/write: both full, beat arrives with a handshake
    tile_ready = 1'b0;
    for (int k = 0; k < TILE_BEATS; k++) send(700 + 3*k);
    for (int k = 0; k < TILE_BEATS; k++) send(800 + 3*k);
    chk("sim_full_tile", tile_out, tile_val(700));
    tile_ready = 1'b1;
    send(900);
    chk("sim_idx", TILE_W'(beat_idx), TILE_W'(1));
    chk("sim_ovf", TILE_W'(overflow), '0);
    chk("sim_count", TILE_W'(tile_count), TILE_W'(4));
    chk("sim_next_tile", tile_out, tile_val(800));
    for (int k = 1; k < TILE_BEATS; k++) begin
      send(900 + 3*k);
      if (k == 1) chk("sim_count2", TILE_W'(tile_count), TILE_W'(5));
    end
    chk("sim_new_valid", TILE_W'(tile_valid), TILE_W'(1));
    chk("sim_new_tile", tile_out, tile_val(900));
    idle();
    chk("sim_count3", TILE_W'(tile_count), TILE_W'(6));

    // Overflow: 13th beat dropped
    tile_ready = 1'b0;
    for (int k = 0; k < TILE_BEATS; k++) send(300 + 3*k);
    for (int k = 0; k < TILE_BEATS; k++) send(400 + 3*k);
    chk("ovf_before", TILE_W'(overflow), '0);
    send(500);
    chk("ovf_set", TILE_W'(overflow), TILE_W'(1));
    chk("ovf_idx", TILE_W'(beat_idx), '0);
    chk("ovf_tile_hold", tile_out, tile_val(300));
    post_out_valid = 1'b0;
    tile_ready     = 1'b1;
    tick();
    chk("ovf_tile_b", tile_out, tile_val(400));
    tick();
    chk("ovf_count", TILE_W'(tile_count), TILE_W'(8));
    tile_ready = 1'b0;
    for (int k = 0; k < TILE_BEATS; k++) send(600 + 3*k);
    chk("ovf_third_valid", TILE_W'(tile_valid), TILE_W'(1));
    chk("ovf_third_tile", tile_out, tile_val(600));
    chk("ovf_sticky", TILE_W'(overflow), TILE_W'(1));
    post_out_valid = 1'b0;
    tile_ready     = 1'b1;
    tick();
    chk("ovf_count2", TILE_W'(tile_count), TILE_W'(9));

    // Mid-tile asynchronous reset
    tile_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1000 + 3*k);
    chk("mid_idx4", TILE_W'(beat_idx), TILE_W'(4));
    post_out_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", TILE_W'(tile_valid), '0);
    chk("mid_rst_idx", TILE_W'(beat_idx), '0);
    chk("mid_rst_count", TILE_W'(tile_count), '0);
    chk("mid_rst_ovf", TILE_W'(overflow), '0);
    #1;
    rst = 1'b0;
    tick();
    tile_ready = 1'b1;
    for (int k = 0; k < TILE_BEATS; k++) send(1100 + 3*k);
    chk("mid_clean_valid", TILE_W'(tile_valid), TILE_W'(1));
    chk("mid_clean_tile", tile_out, tile_val(1100));
    idle();
    chk("mid_clean_count", TILE_W'(tile_count), TILE_W'(1));

    // Back-to-back: 60 beats, ready held high
    for (int i = 0; i < 10*TILE_BEATS; i++) begin
      send(2000 + 3*i);
      if (i % TILE_BEATS == TILE_BEATS-1) begin
        chk("b2b_valid", TILE_W'(tile_valid), TILE_W'(1));
        chk("b2b_tile", tile_out, tile_val(2000 + 3*(i - (TILE_BEATS-1))));
      end else begin
        chk("b2b_gap", TILE_W'(tile_valid), '0);
      end
    end
    idle();
    chk("b2b_count", TILE_W'(tile_count), TILE_W'(11));
    chk("b2b_ovf", TILE_W'(overflow), '0);
    chk("b2b_idle", TILE_W'(tile_valid), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
